// File: rtl/wb_timer_if.sv
// wb_timer_if: Wishbone pipelined bus bundle between an initiator and wb_timer.
// The master modport drives requests; the slave modport answers them.
interface wb_timer_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_stall;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
        input  wb_dat_o, wb_ack, wb_err, wb_stall
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
        output wb_dat_o, wb_ack, wb_err, wb_stall
    );
endinterface

// File: rtl/wb_timer.sv
// wb_timer: RISC-V style machine timer (mtime / mtimecmp) on a Wishbone slave.
// A programmable prescaler produces ticks that advance the 64-bit mtime;
// irq_timer is a registered mtime >= mtimecmp compare.
// Optional build macro WB_TIMER_ERR_EN: accesses to the unmapped offsets
// 0x18/0x1C return wb_err instead of a zero-data wb_ack.
module wb_timer #(
    parameter logic [31:0] PRESCALE_RST = 32'd0,
    parameter logic [63:0] CMP_RST      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic      clk,
    input  logic      rst_n,
    wb_timer_if.slave wb,
    output logic      irq_timer
);

    localparam logic [2:0] OFS_MTIME_LO = 3'd0;
    localparam logic [2:0] OFS_MTIME_HI = 3'd1;
    localparam logic [2:0] OFS_CMP_LO   = 3'd2;
    localparam logic [2:0] OFS_CMP_HI   = 3'd3;
    localparam logic [2:0] OFS_PSC      = 3'd4;
    localparam logic [2:0] OFS_CTRL     = 3'd5;

    // State
    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic [31:0] prescale_r;
    logic [31:0] pcnt_r;
    logic [31:0] shadow_r;
    logic        enable_r;
    logic        irq_r;
    logic        ack_r;
    logic        err_r;
    logic [31:0] dat_r;

    // Decode / next-state
    logic        req_s;
    logic        wr_s;
    logic        rd_s;
    logic [2:0]  ofs_s;
    logic        wr_mlo_s;
    logic        wr_mhi_s;
    logic        wr_clo_s;
    logic        wr_chi_s;
    logic        wr_psc_s;
    logic        wr_ctrl_s;
    logic        tick_s;
    logic [63:0] mtime_inc_s;
    logic [63:0] mtime_nxt_s;
    logic [31:0] rdata_s;
    logic        unused_adr_s;
`ifdef WB_TIMER_ERR_EN
    logic        hole_s;
`endif

    // Replace the bytes of old_v selected by sel with the bytes of new_v.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    // The interconnect has already matched the base address.
    assign unused_adr_s = ^{wb.wb_adr[31:5], wb.wb_adr[1:0]};

    // Request decode: one request per cycle, never stalled.
    always_comb begin
        req_s     = wb.wb_cyc & wb.wb_stb;
        ofs_s     = wb.wb_adr[4:2];
        wr_s      = req_s & wb.wb_we;
        rd_s      = req_s & ~wb.wb_we;
        wr_mlo_s  = wr_s & (ofs_s == OFS_MTIME_LO);
        wr_mhi_s  = wr_s & (ofs_s == OFS_MTIME_HI);
        wr_clo_s  = wr_s & (ofs_s == OFS_CMP_LO);
        wr_chi_s  = wr_s & (ofs_s == OFS_CMP_HI);
        wr_psc_s  = wr_s & (ofs_s == OFS_PSC);
        wr_ctrl_s = wr_s & (ofs_s == OFS_CTRL);
`ifdef WB_TIMER_ERR_EN
        hole_s    = ofs_s[2] & ofs_s[1];
`endif
    end

    // Tick generation; a prescale write restarts the period, so it also
    // swallows the tick of that cycle.
    always_comb begin
        tick_s = enable_r & (pcnt_r == prescale_r) & ~wr_psc_s;
    end

    // mtime next value: a written half takes the bus data, the other half
    // keeps only its own carry-free increment.
    always_comb begin
        mtime_inc_s = mtime_r + 64'd1;
        mtime_nxt_s = tick_s ? mtime_inc_s : mtime_r;
        if (wr_mlo_s) begin
            mtime_nxt_s[31:0]  = byte_merge(mtime_r[31:0], wb.wb_dat_i, wb.wb_sel);
            mtime_nxt_s[63:32] = mtime_r[63:32];
        end else if (wr_mhi_s) begin
            mtime_nxt_s[63:32] = byte_merge(mtime_r[63:32], wb.wb_dat_i, wb.wb_sel);
            mtime_nxt_s[31:0]  = tick_s ? mtime_inc_s[31:0] : mtime_r[31:0];
        end else begin
            mtime_nxt_s = tick_s ? mtime_inc_s : mtime_r;
        end
    end

    // Read data mux; the mtime high word comes from the snapshot.
    always_comb begin
        case (ofs_s)
            OFS_MTIME_LO: rdata_s = mtime_r[31:0];
            OFS_MTIME_HI: rdata_s = shadow_r;
            OFS_CMP_LO:   rdata_s = mtimecmp_r[31:0];
            OFS_CMP_HI:   rdata_s = mtimecmp_r[63:32];
            OFS_PSC:      rdata_s = prescale_r;
            OFS_CTRL:     rdata_s = {31'd0, enable_r};
            default:      rdata_s = 32'd0;
        endcase
    end

    // Prescale counter: wraps at prescale, cleared by a prescale write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_r <= 32'd0;
        end else if (wr_psc_s) begin
            pcnt_r <= 32'd0;
        end else if (enable_r) begin
            pcnt_r <= (pcnt_r == prescale_r) ? 32'd0 : pcnt_r + 32'd1;
        end else begin
            pcnt_r <= pcnt_r;
        end
    end

    // Timer registers and the hi-word snapshot taken on a low-word read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime_r    <= 64'd0;
            mtimecmp_r <= CMP_RST;
            prescale_r <= PRESCALE_RST;
            enable_r   <= 1'b0;
            shadow_r   <= 32'd0;
        end else begin
            mtime_r <= mtime_nxt_s;
            if (wr_clo_s) begin
                mtimecmp_r[31:0] <= byte_merge(mtimecmp_r[31:0], wb.wb_dat_i, wb.wb_sel);
            end else begin
                mtimecmp_r[31:0] <= mtimecmp_r[31:0];
            end
            if (wr_chi_s) begin
                mtimecmp_r[63:32] <= byte_merge(mtimecmp_r[63:32], wb.wb_dat_i, wb.wb_sel);
            end else begin
                mtimecmp_r[63:32] <= mtimecmp_r[63:32];
            end
            if (wr_psc_s) begin
                prescale_r <= byte_merge(prescale_r, wb.wb_dat_i, wb.wb_sel);
            end else begin
                prescale_r <= prescale_r;
            end
            if (wr_ctrl_s && wb.wb_sel[0]) begin
                enable_r <= wb.wb_dat_i[0];
            end else begin
                enable_r <= enable_r;
            end
            if (rd_s && (ofs_s == OFS_MTIME_LO)) begin
                shadow_r <= mtime_r[63:32];
            end else begin
                shadow_r <= shadow_r;
            end
        end
    end

    // Interrupt compare, registered; independent of enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= (mtime_r >= mtimecmp_r);
        end
    end

    // Bus response: ack/err and read data exactly one cycle after the request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            dat_r <= 32'd0;
        end else begin
`ifdef WB_TIMER_ERR_EN
            ack_r <= req_s & ~hole_s;
            err_r <= req_s & hole_s;
`else
            ack_r <= req_s;
            err_r <= 1'b0;
`endif
            dat_r <= rd_s ? rdata_s : 32'd0;
        end
    end

    assign wb.wb_ack   = ack_r;
    assign wb.wb_err   = err_r;
    assign wb.wb_dat_o = dat_r;
    assign wb.wb_stall = 1'b0;
    assign irq_timer   = irq_r;

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter PRESCALE_RST, default 0, reset value of the prescaler register.
REQ-002 SHALL have parameter CMP_RST, default 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port wb_cyc, input, 1, Wishbone cycle.
REQ-006 SHALL have port wb_stb, input, 1, Wishbone strobe.
REQ-007 SHALL have port wb_we, input, 1, write enable.
REQ-008 SHALL have port wb_sel, input, 4, byte selects.
REQ-009 SHALL have port wb_adr, input, 32, byte address; only adr[4:2] decoded, since the interconnect performs the base decode.
REQ-010 SHALL have port wb_dat_i, input, 32, write data.
REQ-011 SHALL have port wb_dat_o, output, 32, read data.
REQ-012 SHALL have port wb_ack, output, 1, transfer acknowledge.
REQ-013 SHALL have port wb_err, output, 1, error acknowledge.
REQ-014 SHALL have port wb_stall, output, 1, pipeline stall; tied 0.
REQ-015 SHALL have port irq_timer, output, 1, timer interrupt to the core irq_timer input.

Function
REQ-016 SHALL map word offsets: 0x00 mtime[31:0], 0x04 mtime[63:32], 0x08 mtimecmp[31:0], 0x0C mtimecmp[63:32], 0x10 prescale[31:0], 0x14 ctrl (bit0 enable, others read 0).
REQ-017 SHALL accept a request on any cycle with wb_cyc&wb_stb, and assert wb_ack exactly one cycle later for one cycle, with wb_dat_o valid in that cycle.
REQ-018 SHALL honour wb_sel per byte on writes, and ignore wb_sel on reads.
REQ-019 SHALL advance a prescale counter each cycle while enable=1; when it equals prescale, it SHALL wrap to 0 and emit a one-cycle tick; prescale=0 gives a tick every cycle.
REQ-020 SHALL increment 64-bit mtime by 1 on each tick, wrapping from all-ones to 0.
REQ-021 SHALL hold mtime and the prescale counter when enable=0.
REQ-022 SHALL give a bus write to mtime priority over a same-cycle tick increment of the written half; the unwritten half still takes any carry-free update.
REQ-023 SHALL clear the prescale counter to 0 on any write to offset 0x10.
REQ-024 SHALL copy mtime[63:32] into a shadow register on a read of offset 0x00; a read of 0x04 SHALL return the shadow, not the live value.
REQ-025 SHALL drive irq_timer registered: irq_timer = (mtime >= mtimecmp, unsigned 64-bit) in the previous cycle, independent of enable.
REQ-026 SHALL, on a write to mtimecmp that makes mtime < mtimecmp, deassert irq_timer within 2 cycles of the ack.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, set mtime=0, mtimecmp=CMP_RST, prescale=PRESCALE_RST, prescale counter=0, enable=0, shadow=0, irq_timer=0, wb_ack=0, wb_err=0, wb_dat_o=0.
REQ-028 SHALL drop any request in flight when reset is asserted mid-transfer, with no ack generated after reset.

Configuration
REQ-029 SHALL, with WB_TIMER_ERR_EN defined, answer accesses to offsets 0x18-0x1C with wb_err (one cycle, same timing as ack), no wb_ack and no state change.
REQ-030 SHALL, without WB_TIMER_ERR_EN, answer those offsets with wb_ack, read data 0 and writes ignored; wb_err then constant 0.

Verification
REQ-031 Reset, write ctrl=1, prescale=0 -> after 10 enabled cycles mtime[31:0] reads 10 (±1 for read latency); irq_timer=0.
REQ-032 prescale=3, enable -> mtime increments once every 4 cycles; write 0x10 mid-count restarts the 4-cycle spacing.
REQ-033 mtime=0xFFFF_FFFF_FFFF_FFFE, prescale=0, enable -> reads show wrap to 0; lo read snapshot makes the hi read 0 after carry.
REQ-034 mtimecmp=0x20, mtime counting from 0 -> irq_timer rises one cycle after mtime reaches 0x20; writing mtimecmp_hi=1 clears it within 2 cycles.
REQ-035 Write wb_sel=4'b0010 data 0xAABBCCDD to mtimecmp_lo after reset -> reads 0xFFFFCCFF.
REQ-036 Access to offset 0x18 -> wb_err pulse with ERR_EN defined, else wb_ack with data 0; back-to-back requests each acked one cycle later.
